// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream image loader driving the write port of the 256x16 program memory.
// Optional build macro LOADER_CLEAR_EN zero-fills the words past the image before releasing the CPU.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_N = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN,
    S_HI,
    S_LO,
    S_SUM,
    S_DONE,
    S_ERR
`ifdef LOADER_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic              xfer;

  assign xfer = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    words_d     = words_q;
    n_d         = n_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    hi_d        = hi_q;

    case (state_q)
      S_LEN, S_ERR: begin
        // From S_ERR the next byte is taken as a fresh LEN, allowing immediate retry.
        if (xfer) begin
          n_d     = (in_byte == 8'h00) ? FULL_N : CNT_W'(in_byte);
          sum_d   = 8'h00;
          idx_d   = '0;
          words_d = '0;
          err_d   = 1'b0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = in_byte;
          sum_d   = sum_q ^ in_byte;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = DATA_W'({hi_q, in_byte});
          sum_d       = sum_q ^ in_byte;
          idx_d       = idx_q + 1'b1;
          words_d     = words_q + 1'b1;
          state_d     = (words_q + 1'b1 == n_q) ? S_SUM : S_HI;
        end
      end
      S_SUM: begin
        if (xfer) begin
          if (in_byte == sum_q) begin
`ifdef LOADER_CLEAR_EN
            if (n_q == FULL_N) begin
              state_d   = S_DONE;
              done_d    = 1'b1;
              cpu_rst_d = 1'b0;
            end else begin
              state_d = S_CLEAR;
            end
`else
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
`endif
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`ifdef LOADER_CLEAR_EN
      S_CLEAR: begin
        // Release the CPU only once the write to the top address has been issued.
        if (mem_we_q && (mem_addr_q == '1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = '0;
          idx_d       = idx_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase

    in_ready_d = (state_d != S_DONE);
`ifdef LOADER_CLEAR_EN
    if (state_d == S_CLEAR) in_ready_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LEN;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      n_q         <= '0;
      sum_q       <= 8'h00;
      idx_q       <= '0;
      hi_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
      n_q         <= n_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
